// File: rtl/spi_bus_arb.sv
// Two-port arbiter in front of one shared SPI master: grants a requester, launches its
// latched command, returns the response with a done pulse, and aborts hung transactions.
module spi_bus_arb #(
  parameter int TIMEOUT    = 1024,
  parameter int GAP_CYCLES = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] cmd0,
  input  logic [15:0] cmd1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [15:0] rd_data,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  output logic        gnt_id,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WRT  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

  logic [1:0]    state;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic          last_gnt;
  logic          win;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    win = req1;
    if (req0 && req1) win = (FIXED_PRIO != 0) ? 1'b0 : ~last_gnt;
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tcnt     <= '0;
      gcnt     <= '0;
      last_gnt <= 1'b1;
      gnt_id   <= 1'b0;
      spi_cmd  <= '0;
      rd_data  <= '0;
      spi_wrt  <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      spi_wrt <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt_id   <= win;
            last_gnt <= win;
            spi_cmd  <= win ? cmd1 : cmd0;
            spi_wrt  <= 1'b1;
            busy     <= 1'b1;
            state    <= WRT;
          end
        end
        WRT: begin
          // The strobe cycle already counts toward the watchdog window, so the
          // abort lands exactly TIMEOUT cycles after spi_wrt.
          tcnt  <= TW'(1);
          state <= WAIT;
        end
        WAIT: begin
          if (spi_done) begin
            rd_data <= spi_rd_data;
            done0   <= ~gnt_id;
            done1   <= gnt_id;
            gcnt    <= '0;
            state   <= GAP;
          end else if (tcnt == T_LAST) begin
            rd_data <= '0;
            done0   <= ~gnt_id;
            done1   <= gnt_id;
            err0    <= ~gnt_id;
            err1    <= gnt_id;
            gcnt    <= '0;
            state   <= GAP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        GAP: begin
          if (gcnt == G_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
